// File: rtl/spu_imm_load_pipe.sv
// spu_imm_load_pipe: stallable/flushable immediate-load pipe (ILH/ILHU/IL/ILA/IOHL)
// Defining SPU_IMM_FWD_EN adds per-stage forwarding ports fwd_valid/fwd_addr/fwd_data.
module spu_imm_load_pipe #(
    parameter int DATA_W  = 128,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 7,
    parameter int IMM_W   = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [10:0]       in_opcode,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [ADDR_W-1:0] in_rt_addr,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_rt_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              ill_op,
    output logic              busy
`ifdef SPU_IMM_FWD_EN
    ,
    output logic [LATENCY-1:0]        fwd_valid,
    output logic [LATENCY*ADDR_W-1:0] fwd_addr,
    output logic [LATENCY*DATA_W-1:0] fwd_data
`endif
);
    localparam int W = DATA_W / 32;
    logic [LATENCY-1:0]             vld_q, vld_d;
    logic [LATENCY-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [LATENCY-1:0][DATA_W-1:0] data_q, data_d;
    logic                           ill_q, ill_d;
    logic [15:0]                    i16;
    logic                           is_ilh, is_ilhu, is_il, is_ila, is_iohl, legal, acc;
    logic [DATA_W-1:0]              res;
    assign i16     = in_imm[15:0];
    assign is_ilh  = in_opcode == 11'b00010000011;
    assign is_ilhu = in_opcode == 11'b00010000010;
    assign is_il   = in_opcode == 11'b00010000001;
    assign is_ila  = in_opcode == 11'b00000100001;
    assign is_iohl = in_opcode == 11'b00011000001;
    assign legal   = is_ilh | is_ilhu | is_il | is_ila | is_iohl;
    assign acc     = in_valid & ~stall & ~flush;
    always_comb begin
        res = '0;
        for (int i = 0; i < W; i++)
            res[32*i +: 32] = is_ilh  ? {i16, i16} :
                              is_ilhu ? {i16, 16'h0} :
                              is_il   ? {{16{i16[15]}}, i16} :
                              is_ila  ? 32'(in_imm[17:0]) :
                              is_iohl ? (in_rt_data[32*i +: 32] | {16'h0, i16}) : 32'h0;
    end
    // A stall holds every stage in place; flush only kills valids, data may go stale.
    always_comb begin
        vld_d     = '0;
        addr_d    = addr_q;
        data_d    = data_q;
        vld_d[0]  = ~flush & (stall ? vld_q[0] : acc & legal);
        addr_d[0] = stall ? addr_q[0] : in_rt_addr;
        data_d[0] = stall ? data_q[0] : res;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]  = ~flush & (stall ? vld_q[i] : vld_q[i-1]);
            addr_d[i] = stall ? addr_q[i] : addr_q[i-1];
            data_d[i] = stall ? data_q[i] : data_q[i-1];
        end
        ill_d = acc & ~legal;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            ill_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ill_q  <= ill_d;
        end
    end
    assign out_valid   = vld_q[LATENCY-1];
    assign out_rt_addr = addr_q[LATENCY-1];
    assign out_data    = data_q[LATENCY-1];
    assign ill_op      = ill_q;
    assign busy        = |vld_q;
`ifdef SPU_IMM_FWD_EN
    assign fwd_valid = vld_q;
    assign fwd_addr  = addr_q;
    assign fwd_data  = data_q;
`endif
endmodule

// File: tb/tb_spu_imm_load_pipe.sv
// tb_spu_imm_load_pipe: directed literal checks plus randomized run against a queue-based model
module tb_spu_imm_load_pipe;
    localparam int LAT = 2;
    localparam int DW  = 128;
    localparam int AW  = 7;
    localparam int IW  = 18;
    localparam logic [10:0] OP_ILH  = 11'b00010000011;
    localparam logic [10:0] OP_ILHU = 11'b00010000010;
    localparam logic [10:0] OP_IL   = 11'b00010000001;
    localparam logic [10:0] OP_ILA  = 11'b00000100001;
    localparam logic [10:0] OP_IOHL = 11'b00011000001;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          in_valid = 0;
    logic [10:0]   in_opcode = '0;
    logic [IW-1:0] in_imm = '0;
    logic [AW-1:0] in_rt_addr = '0;
    logic [DW-1:0] in_rt_data = '0;
    logic          stall = 0;
    logic          flush = 0;
    logic          out_valid, ill_op, busy;
    logic [AW-1:0] out_rt_addr;
    logic [DW-1:0] out_data;
`ifdef SPU_IMM_FWD_EN
    logic [LAT-1:0]    fwd_valid;
    logic [LAT*AW-1:0] fwd_addr;
    logic [LAT*DW-1:0] fwd_data;
`endif

    spu_imm_load_pipe #(.DATA_W(DW), .LATENCY(LAT), .ADDR_W(AW), .IMM_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_opcode(in_opcode),
        .in_imm(in_imm), .in_rt_addr(in_rt_addr), .in_rt_data(in_rt_data),
        .stall(stall), .flush(flush), .out_valid(out_valid), .out_rt_addr(out_rt_addr),
        .out_data(out_data), .ill_op(ill_op), .busy(busy)
`ifdef SPU_IMM_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [10:0] op);
        return op == OP_ILH || op == OP_ILHU || op == OP_IL || op == OP_ILA || op == OP_IOHL;
    endfunction

    function automatic logic [DW-1:0] expect_data(input logic [10:0] op, input logic [IW-1:0] imm,
                                                  input logic [DW-1:0] rt);
        logic [DW-1:0] r;
        int sv;
        r = '0;
        sv = int'($signed(imm[15:0]));
        for (int h = 0; h < DW/16; h++)
            if (op == OP_ILH) r[16*h +: 16] = imm[15:0];
        for (int w = 0; w < DW/32; w++) begin
            if (op == OP_ILHU) r[32*w +: 32] = imm[15:0] * 32'h10000;
            if (op == OP_IL)   r[32*w +: 32] = 32'(sv);
            if (op == OP_ILA)  r[32*w +: 32] = 32'(imm[17:0]);
            if (op == OP_IOHL) r[32*w +: 32] = rt[32*w +: 32] | 32'(imm[15:0]);
        end
        return r;
    endfunction

    // Model: each op is released once it has seen LAT unstalled edges since acceptance.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            age;
    } ent_t;
    ent_t q[$];
    logic          ev = 0, eill = 0;
    logic [AW-1:0] ea = '0;
    logic [DW-1:0] ed = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            ev = 0; ea = '0; ed = '0; eill = 0;
        end else begin
            eill = in_valid && !stall && !flush && !is_legal(in_opcode);
            if (flush) begin
                q.delete();
                ev = 0;
            end else if (!stall) begin
                foreach (q[i]) q[i].age++;
                if (in_valid && is_legal(in_opcode))
                    q.push_back('{in_rt_addr, expect_data(in_opcode, in_imm, in_rt_data), 1});
                while (q.size() > 0 && q[0].age > LAT) void'(q.pop_front());
                ev = 0;
                if (q.size() > 0 && q[0].age == LAT) begin
                    ev = 1; ea = q[0].a; ed = q[0].d;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", DW'(out_valid), DW'(ev));
            chk("ill_op", DW'(ill_op), DW'(eill));
            chk("busy", DW'(busy), DW'(q.size() > 0));
            if (ev) begin
                chk("out_rt_addr", DW'(out_rt_addr), DW'(ea));
                chk("out_data", out_data, ed);
            end
        end
    end

    task automatic drive(input logic rn, input logic v, input logic [10:0] op, input logic [IW-1:0] imm,
                         input logic [AW-1:0] rt, input logic [DW-1:0] rtd, input logic st, input logic fl);
        @(negedge clk);
        #1;
        rst_n = rn; in_valid = v; in_opcode = op; in_imm = imm;
        in_rt_addr = rt; in_rt_data = rtd; stall = st; flush = fl;
    endtask

    task automatic idle();
        drive(1, 0, '0, '0, '0, '0, 0, 0);
    endtask

    task automatic one(input string n, input logic [10:0] op, input logic [IW-1:0] imm,
                       input logic [AW-1:0] rt, input logic [DW-1:0] rtd, input logic [DW-1:0] lit);
        int k;
        drive(1, 1, op, imm, rt, rtd, 0, 0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            in_valid = 0;
        end while (!out_valid && k < 20);
        chk({n, "_lat"}, DW'(k), DW'(LAT));
        chk({n, "_data"}, out_data, lit);
        chk({n, "_addr"}, DW'(out_rt_addr), DW'(rt));
    endtask

    initial begin
        logic [10:0] ops [5];
        ops = '{OP_ILH, OP_ILHU, OP_IL, OP_ILA, OP_IOHL};
        repeat (3) @(posedge clk);
        drive(1, 0, '0, '0, '0, '0, 0, 0);
        @(negedge clk);
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_ill_op", DW'(ill_op), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_addr", DW'(out_rt_addr), '0);
        chk_en = 1;

        one("ilhu", OP_ILHU, 18'h0ABCD, 7'd5, '0, {4{32'hABCD0000}});
        one("il", OP_IL, 18'h08001, 7'd9, '0, {4{32'hFFFF8001}});
        one("ilh", OP_ILH, 18'h01234, 7'd1, '0, {8{16'h1234}});
        one("ila", OP_ILA, 18'h3FFFF, 7'd127, '0, {4{32'h0003FFFF}});
        one("iohl", OP_IOHL, 18'h000AA, 7'd33,
            {32'h00005555, 32'h0, 32'hFFFF0000, 32'h12340000},
            {32'h000055FF, 32'h000000AA, 32'hFFFF00AA, 32'h123400AA});
        repeat (2) idle();

        // Four back-to-back ops with a two-cycle stall holding the third.
        drive(1, 1, OP_IL, 18'h00001, 7'd10, '0, 0, 0);
        drive(1, 1, OP_IL, 18'h00002, 7'd11, '0, 0, 0);
        drive(1, 1, OP_IL, 18'h00003, 7'd12, '0, 1, 0);
        drive(1, 1, OP_IL, 18'h00003, 7'd12, '0, 1, 0);
        drive(1, 1, OP_IL, 18'h00003, 7'd12, '0, 0, 0);
        drive(1, 1, OP_IL, 18'h00004, 7'd13, '0, 0, 0);
        repeat (4) idle();

        // Flush with two ops in flight plus a coincident issue.
        drive(1, 1, OP_ILH, 18'h00111, 7'd20, '0, 0, 0);
        drive(1, 1, OP_ILH, 18'h00222, 7'd21, '0, 0, 0);
        drive(1, 1, OP_ILH, 18'h00333, 7'd22, '0, 0, 1);
        idle();
        chk("flush_busy", DW'(busy), '0);
        chk("flush_out_valid", DW'(out_valid), '0);
        repeat (3) idle();

        drive(1, 1, 11'h7FF, 18'h00055, 7'd3, '0, 0, 0);
        idle();
        chk("ill_pulse", DW'(ill_op), DW'(1'b1));
        idle();
        chk("ill_clear", DW'(ill_op), '0);
        chk("ill_no_out", DW'(out_valid), '0);

        drive(1, 1, OP_ILA, 18'h00007, 7'd40, '0, 0, 0);
        drive(1, 1, OP_ILA, 18'h00008, 7'd41, '0, 0, 0);
        drive(0, 1, OP_ILA, 18'h00009, 7'd42, '0, 0, 0);
        idle();
        chk("rstmid_out_valid", DW'(out_valid), '0);
        chk("rstmid_busy", DW'(busy), '0);
`ifdef SPU_IMM_FWD_EN
        chk("rstmid_fwd_valid", DW'(fwd_valid), '0);
`endif
        repeat (3) idle();

        for (int c = 0; c < 3000; c++) begin
            int sel;
            logic [10:0] op;
            sel = $urandom_range(0, 5);
            op = (sel == 5) ? 11'($urandom) : ops[sel];
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, op, IW'($urandom),
                  AW'($urandom), {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
        end
        repeat (LAT + 2) idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
